// File: rtl/wb_b3_pkg.sv
// wb_b3_pkg
//   Shared definitions for the Wishbone B3 burst master:
//   - CTI codes (cycle type identifier)
//   - BTE codes (burst type extension)
//   - FSM state type
package wb_b3_pkg;

  localparam logic [2:0] CTI_CLASSIC = 3'b000;
  localparam logic [2:0] CTI_CONST   = 3'b001;
  localparam logic [2:0] CTI_INCR    = 3'b010;
  localparam logic [2:0] CTI_EOB     = 3'b111;

  localparam logic [1:0] BTE_LINEAR  = 2'b00;
  localparam logic [1:0] BTE_WRAP4   = 2'b01;
  localparam logic [1:0] BTE_WRAP8   = 2'b10;
  localparam logic [1:0] BTE_WRAP16  = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUS  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

endpackage

// File: rtl/wb_b3_adr_gen.sv
// wb_b3_adr_gen
//   Combinational next-beat address for a Wishbone B3 burst.
//   Ports:
//     adr_i      - current byte address (word aligned)
//     bte_i      - burst type extension (linear / wrap4 / wrap8 / wrap16)
//     adr_nxt_o  - address of the following beat
//   Linear bursts add dw/8 over the full width. Wrapping bursts add dw/8
//   but only keep the result in the low 2/3/4 word-address bits; all other
//   bits (byte offset and the upper address) come from the current address.
module wb_b3_adr_gen
  import wb_b3_pkg::*;
#(
  parameter int dw = 32,
  parameter int aw = 32
) (
  input  logic [aw-1:0] adr_i,
  input  logic [1:0]    bte_i,
  output logic [aw-1:0] adr_nxt_o
);

  localparam int STEP = dw / 8;
  localparam int SH   = $clog2(STEP);

  // Masks selecting the wrapping word-address bits, positioned above the
  // byte-offset bits.
  localparam logic [aw-1:0] MASK_WRAP4  = aw'(3)  << SH;
  localparam logic [aw-1:0] MASK_WRAP8  = aw'(7)  << SH;
  localparam logic [aw-1:0] MASK_WRAP16 = aw'(15) << SH;

  logic [aw-1:0] adr_inc;
  logic [aw-1:0] keep_mask;

  always_comb begin
    adr_inc   = adr_i + aw'(STEP);
    keep_mask = '1;
    case (bte_i)
      BTE_WRAP4:  keep_mask = MASK_WRAP4;
      BTE_WRAP8:  keep_mask = MASK_WRAP8;
      BTE_WRAP16: keep_mask = MASK_WRAP16;
      default:    keep_mask = '1;
    endcase
    adr_nxt_o = (adr_i & ~keep_mask) | (adr_inc & keep_mask);
  end

endmodule

// File: rtl/wb_b3_burst_master.sv
// wb_b3_burst_master
//   Converts a simple command/data interface into Wishbone B3 incrementing
//   or wrapping bursts of 1..16 beats.
//   Command side:
//     cmd_valid_i/cmd_ready_o handshake; cmd_we_i, cmd_adr_i, cmd_len_i
//     (beats-1), cmd_bte_i are captured on accept.
//   Data side:
//     wr_dat_i/wr_valid_i/wr_ready_o  - write beats (wr_ready_o = beat acked)
//     rd_dat_o/rd_valid_o             - read beats, one-cycle pulse per ack
//     done_o                          - one-cycle pulse when a command ends
//     err_o                           - sticky error/timeout flag of the last
//                                       command, cleared on the next accept
//   Wishbone B3 master: wb_adr_o, wb_dat_o, wb_sel_o, wb_we_o, wb_cyc_o,
//     wb_stb_o, wb_cti_o, wb_bte_o, wb_dat_i, wb_ack_i, wb_err_i, wb_rty_i.
//   Clock/reset: wb_clk_i, wb_rst_n_i (asynchronous, active-low).
//   Optional feature: define WB_MASTER_TIMEOUT_EN to enable a strobe watchdog
//     of TIMEOUT_CYCLES cycles that aborts the burst and flags err_o.
module wb_b3_burst_master
  import wb_b3_pkg::*;
#(
  parameter int dw             = 32,
  parameter int aw             = 32,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic            wb_clk_i,
  input  logic            wb_rst_n_i,
  // command
  input  logic            cmd_valid_i,
  output logic            cmd_ready_o,
  input  logic            cmd_we_i,
  input  logic [aw-1:0]   cmd_adr_i,
  input  logic [3:0]      cmd_len_i,
  input  logic [1:0]      cmd_bte_i,
  // data
  input  logic [dw-1:0]   wr_dat_i,
  input  logic            wr_valid_i,
  output logic            wr_ready_o,
  output logic [dw-1:0]   rd_dat_o,
  output logic            rd_valid_o,
  output logic            done_o,
  output logic            err_o,
  // wishbone
  output logic [aw-1:0]   wb_adr_o,
  output logic [dw-1:0]   wb_dat_o,
  output logic [dw/8-1:0] wb_sel_o,
  output logic            wb_we_o,
  output logic            wb_cyc_o,
  output logic            wb_stb_o,
  output logic [2:0]      wb_cti_o,
  output logic [1:0]      wb_bte_o,
  input  logic [dw-1:0]   wb_dat_i,
  input  logic            wb_ack_i,
  input  logic            wb_err_i,
  input  logic            wb_rty_i
);

  state_e        state_q, state_d;
  logic          we_q, we_d;
  logic [aw-1:0] adr_q, adr_d;
  logic [3:0]    len_q, len_d;
  logic [1:0]    bte_q, bte_d;
  logic [3:0]    cnt_q, cnt_d;
  logic          cyc_q, cyc_d;
  logic          err_q, err_d;
  logic          done_q, done_d;

  logic [aw-1:0] adr_nxt;
  logic          stb;
  logic          ack_hit;
  logic          err_hit;
  logic          rty_hit;
  logic          timeout_hit;
  logic [2:0]    cti;

  wb_b3_adr_gen #(
    .dw (dw),
    .aw (aw)
  ) u_adr_gen (
    .adr_i     (adr_q),
    .bte_i     (bte_q),
    .adr_nxt_o (adr_nxt)
  );

  // Writes only strobe when a data word is present, so the bus sees wait
  // states instead of stale data.
  assign stb = cyc_q & (we_q ? wr_valid_i : 1'b1);

  // Responses are qualified by cyc so anything arriving outside a cycle is
  // ignored. Priority err > rty > ack: an err together with ack never
  // counts as a data beat.
  assign err_hit = cyc_q & wb_err_i;
  assign rty_hit = cyc_q & wb_rty_i & ~wb_err_i;
  assign ack_hit = stb & wb_ack_i & ~wb_err_i & ~wb_rty_i;

`ifdef WB_MASTER_TIMEOUT_EN
  localparam int TmoW = (TIMEOUT_CYCLES < 2) ? 1 : $clog2(TIMEOUT_CYCLES + 1);

  logic [TmoW-1:0] tmo_q, tmo_d;

  // Fires on the TIMEOUT_CYCLES-th consecutive strobe cycle without an ack.
  assign timeout_hit = stb & ~wb_ack_i & ~wb_err_i & ~wb_rty_i &
                       (tmo_q == TmoW'(TIMEOUT_CYCLES - 1));

  always_comb begin
    tmo_d = tmo_q;
    if (state_q != ST_BUS) begin
      tmo_d = '0;
    end else if (wb_ack_i) begin
      tmo_d = '0;
    end else if (stb) begin
      tmo_d = tmo_q + TmoW'(1);
    end
  end

  always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
    if (!wb_rst_n_i) begin
      tmo_q <= '0;
    end else begin
      tmo_q <= tmo_d;
    end
  end
`else
  assign timeout_hit = 1'b0;
`endif

  // Single beats are classic cycles; bursts are incrementing with an
  // end-of-burst marker on the final beat.
  always_comb begin
    cti = CTI_CLASSIC;
    if (cyc_q && (len_q != 4'd0)) begin
      cti = (cnt_q != 4'd0) ? CTI_INCR : CTI_EOB;
    end
  end

  always_comb begin
    state_d = state_q;
    we_d    = we_q;
    adr_d   = adr_q;
    len_d   = len_q;
    bte_d   = bte_q;
    cnt_d   = cnt_q;
    cyc_d   = cyc_q;
    err_d   = err_q;
    done_d  = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (cmd_valid_i) begin
          we_d    = cmd_we_i;
          adr_d   = cmd_adr_i;
          len_d   = cmd_len_i;
          bte_d   = cmd_bte_i;
          cnt_d   = cmd_len_i;
          cyc_d   = 1'b1;
          err_d   = 1'b0;
          state_d = ST_BUS;
        end
      end

      ST_BUS: begin
        if (err_hit || timeout_hit) begin
          err_d   = 1'b1;
          cyc_d   = 1'b0;
          done_d  = 1'b1;
          state_d = ST_DONE;
        end else if (rty_hit) begin
          cyc_d   = 1'b0;
          done_d  = 1'b1;
          state_d = ST_DONE;
        end else if (ack_hit) begin
          // Address is advanced in the ack cycle so the next beat can be
          // presented immediately.
          adr_d = adr_nxt;
          if (cnt_q == 4'd0) begin
            cyc_d   = 1'b0;
            done_d  = 1'b1;
            state_d = ST_DONE;
          end else begin
            cnt_d = cnt_q - 4'd1;
          end
        end
      end

      ST_DONE: begin
        state_d = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
        cyc_d   = 1'b0;
      end
    endcase
  end

  always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
    if (!wb_rst_n_i) begin
      state_q <= ST_IDLE;
      we_q    <= 1'b0;
      adr_q   <= '0;
      len_q   <= 4'd0;
      bte_q   <= BTE_LINEAR;
      cnt_q   <= 4'd0;
      cyc_q   <= 1'b0;
      err_q   <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      we_q    <= we_d;
      adr_q   <= adr_d;
      len_q   <= len_d;
      bte_q   <= bte_d;
      cnt_q   <= cnt_d;
      cyc_q   <= cyc_d;
      err_q   <= err_d;
      done_q  <= done_d;
    end
  end

  assign cmd_ready_o = (state_q == ST_IDLE);
  assign wb_cyc_o    = cyc_q;
  assign wb_stb_o    = stb;
  assign wb_we_o     = cyc_q & we_q;
  assign wb_adr_o    = adr_q;
  assign wb_dat_o    = (cyc_q & we_q) ? wr_dat_i : '0;
  assign wb_sel_o    = '1;
  assign wb_cti_o    = cti;
  assign wb_bte_o    = bte_q;
  assign rd_dat_o    = wb_dat_i;
  assign rd_valid_o  = ack_hit & ~we_q;
  assign wr_ready_o  = ack_hit & we_q;
  assign done_o      = done_q;
  assign err_o       = err_q;

endmodule

// File: tb/tb_wb_b3_burst_master.sv
module tb_wb_b3_burst_master;

  localparam int DW = 32;
  localparam int AW = 32;
  localparam logic H = 1'b1;
  localparam logic L = 1'b0;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          cmd_valid = 1'b0;
  logic          cmd_ready;
  logic          cmd_we = 1'b0;
  logic [AW-1:0] cmd_adr = '0;
  logic [3:0]    cmd_len = '0;
  logic [1:0]    cmd_bte = '0;
  logic [DW-1:0] wr_dat = '0;
  logic          wr_valid = 1'b0;
  logic          wr_ready;
  logic [DW-1:0] rd_dat;
  logic          rd_valid;
  logic          done;
  logic          err;
  logic [AW-1:0] wb_adr;
  logic [DW-1:0] wb_dat_o;
  logic [DW/8-1:0] wb_sel;
  logic          wb_we;
  logic          wb_cyc;
  logic          wb_stb;
  logic [2:0]    wb_cti;
  logic [1:0]    wb_bte;
  logic [DW-1:0] wb_dat_i = '0;
  logic          wb_ack = 1'b0;
  logic          wb_err = 1'b0;
  logic          wb_rty = 1'b0;

  always #5 clk = ~clk;

  wb_b3_burst_master #(
    .dw             (DW),
    .aw             (AW),
    .TIMEOUT_CYCLES (8)
  ) dut (
    .wb_clk_i    (clk),
    .wb_rst_n_i  (rst_n),
    .cmd_valid_i (cmd_valid),
    .cmd_ready_o (cmd_ready),
    .cmd_we_i    (cmd_we),
    .cmd_adr_i   (cmd_adr),
    .cmd_len_i   (cmd_len),
    .cmd_bte_i   (cmd_bte),
    .wr_dat_i    (wr_dat),
    .wr_valid_i  (wr_valid),
    .wr_ready_o  (wr_ready),
    .rd_dat_o    (rd_dat),
    .rd_valid_o  (rd_valid),
    .done_o      (done),
    .err_o       (err),
    .wb_adr_o    (wb_adr),
    .wb_dat_o    (wb_dat_o),
    .wb_sel_o    (wb_sel),
    .wb_we_o     (wb_we),
    .wb_cyc_o    (wb_cyc),
    .wb_stb_o    (wb_stb),
    .wb_cti_o    (wb_cti),
    .wb_bte_o    (wb_bte),
    .wb_dat_i    (wb_dat_i),
    .wb_ack_i    (wb_ack),
    .wb_err_i    (wb_err),
    .wb_rty_i    (wb_rty)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end else begin
      $display("ok   %s: %h", name, act);
    end
  endtask

  // One record per clock cycle: inputs held for that cycle, outputs expected
  // in that same cycle.
  typedef struct {
    logic          cv;
    logic          cwe;
    logic [31:0]   cadr;
    logic [3:0]    clen;
    logic [1:0]    cbte;
    logic          wv;
    logic          ack;
    logic          er;
    logic          rty;
    logic          e_rdy;
    logic          e_cyc;
    logic          e_stb;
    logic          e_we;
    logic [31:0]   e_adr;
    logic [2:0]    e_cti;
    logic [1:0]    e_bte;
    logic          e_rdv;
    logic          e_wrr;
    logic          e_done;
    logic          e_err;
  } vec_t;

  localparam int NV = 26;
  vec_t vt[NV];

  function automatic vec_t mk(
    input logic cv, input logic cwe, input logic [31:0] cadr, input logic [3:0] clen,
    input logic [1:0] cbte, input logic wv, input logic ack, input logic er, input logic rty,
    input logic e_rdy, input logic e_cyc, input logic e_stb, input logic e_we,
    input logic [31:0] e_adr, input logic [2:0] e_cti, input logic [1:0] e_bte,
    input logic e_rdv, input logic e_wrr, input logic e_done, input logic e_err);
    vec_t v;
    v.cv = cv; v.cwe = cwe; v.cadr = cadr; v.clen = clen; v.cbte = cbte;
    v.wv = wv; v.ack = ack; v.er = er; v.rty = rty;
    v.e_rdy = e_rdy; v.e_cyc = e_cyc; v.e_stb = e_stb; v.e_we = e_we;
    v.e_adr = e_adr; v.e_cti = e_cti; v.e_bte = e_bte;
    v.e_rdv = e_rdv; v.e_wrr = e_wrr; v.e_done = e_done; v.e_err = e_err;
    return v;
  endfunction

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

  initial begin : main
    int done_seen;
    int stb_cnt;

    //            cv cwe adr         len   bte    wv ack er rty | rdy cyc stb we adr        cti     bte    rdv wrr dn er
    // linear read, 4 beats from 0x0
    vt[0]  = mk(H, L, 32'h0,   4'd3, 2'b00, L, L, L, L,   H, L, L, L, 32'h0,   3'b000, 2'b00, L, L, L, L);
    vt[1]  = mk(L, L, 32'h0,   4'd0, 2'b00, L, H, L, L,   L, H, H, L, 32'h0,   3'b010, 2'b00, H, L, L, L);
    vt[2]  = mk(L, L, 32'h0,   4'd0, 2'b00, L, H, L, L,   L, H, H, L, 32'h4,   3'b010, 2'b00, H, L, L, L);
    vt[3]  = mk(L, L, 32'h0,   4'd0, 2'b00, L, H, L, L,   L, H, H, L, 32'h8,   3'b010, 2'b00, H, L, L, L);
    vt[4]  = mk(L, L, 32'h0,   4'd0, 2'b00, L, H, L, L,   L, H, H, L, 32'hC,   3'b111, 2'b00, H, L, L, L);
    vt[5]  = mk(L, L, 32'h0,   4'd0, 2'b00, L, L, L, L,   L, L, L, L, 32'h10,  3'b000, 2'b00, L, L, H, L);
    // wrap4 write from 0x8, accepted in the cycle right after DONE
    vt[6]  = mk(H, H, 32'h8,   4'd3, 2'b01, H, L, L, L,   H, L, L, L, 32'h10,  3'b000, 2'b00, L, L, L, L);
    vt[7]  = mk(L, L, 32'h0,   4'd0, 2'b00, H, H, L, L,   L, H, H, H, 32'h8,   3'b010, 2'b01, L, H, L, L);
    vt[8]  = mk(L, L, 32'h0,   4'd0, 2'b00, H, H, L, L,   L, H, H, H, 32'hC,   3'b010, 2'b01, L, H, L, L);
    vt[9]  = mk(L, L, 32'h0,   4'd0, 2'b00, H, H, L, L,   L, H, H, H, 32'h0,   3'b010, 2'b01, L, H, L, L);
    vt[10] = mk(L, L, 32'h0,   4'd0, 2'b00, H, H, L, L,   L, H, H, H, 32'h4,   3'b111, 2'b01, L, H, L, L);
    vt[11] = mk(L, L, 32'h0,   4'd0, 2'b00, L, L, L, L,   L, L, L, L, 32'h8,   3'b000, 2'b01, L, L, H, L);
    // single read, err together with ack: err wins, no data beat
    vt[12] = mk(H, L, 32'h100, 4'd0, 2'b00, L, L, L, L,   H, L, L, L, 32'h8,   3'b000, 2'b01, L, L, L, L);
    vt[13] = mk(L, L, 32'h0,   4'd0, 2'b00, L, H, H, L,   L, H, H, L, 32'h100, 3'b000, 2'b00, L, L, L, L);
    vt[14] = mk(L, L, 32'h0,   4'd0, 2'b00, L, L, L, L,   L, L, L, L, 32'h100, 3'b000, 2'b00, L, L, H, H);
    // err_o stays sticky until the next accept; retry ends the burst cleanly
    vt[15] = mk(H, L, 32'h20,  4'd1, 2'b00, L, L, L, L,   H, L, L, L, 32'h100, 3'b000, 2'b00, L, L, L, H);
    vt[16] = mk(L, L, 32'h0,   4'd0, 2'b00, L, L, L, H,   L, H, H, L, 32'h20,  3'b010, 2'b00, L, L, L, L);
    vt[17] = mk(L, L, 32'h0,   4'd0, 2'b00, L, L, L, L,   L, L, L, L, 32'h20,  3'b000, 2'b00, L, L, H, L);
    // responses while cyc=0 are ignored
    vt[18] = mk(L, L, 32'h0,   4'd0, 2'b00, L, H, H, L,   H, L, L, L, 32'h20,  3'b000, 2'b00, L, L, L, L);
    // wrap8 read from 0x38: upper word-address bit held
    vt[19] = mk(H, L, 32'h38,  4'd3, 2'b10, L, L, L, L,   H, L, L, L, 32'h20,  3'b000, 2'b00, L, L, L, L);
    vt[20] = mk(L, L, 32'h0,   4'd0, 2'b00, L, H, L, L,   L, H, H, L, 32'h38,  3'b010, 2'b10, H, L, L, L);
    vt[21] = mk(L, L, 32'h0,   4'd0, 2'b00, L, H, L, L,   L, H, H, L, 32'h3C,  3'b010, 2'b10, H, L, L, L);
    vt[22] = mk(L, L, 32'h0,   4'd0, 2'b00, L, H, L, L,   L, H, H, L, 32'h20,  3'b010, 2'b10, H, L, L, L);
    vt[23] = mk(L, L, 32'h0,   4'd0, 2'b00, L, H, L, L,   L, H, H, L, 32'h24,  3'b111, 2'b10, H, L, L, L);
    vt[24] = mk(L, L, 32'h0,   4'd0, 2'b00, L, L, L, L,   L, L, L, L, 32'h28,  3'b000, 2'b10, L, L, H, L);
    vt[25] = mk(L, L, 32'h0,   4'd0, 2'b00, L, L, L, L,   H, L, L, L, 32'h28,  3'b000, 2'b10, L, L, L, L);

    // ---------------- reset state ----------------
    #12;
    check("rst cyc/stb/we", 64'({wb_cyc, wb_stb, wb_we}), 64'(3'b000));
    check("rst rdv/wrr/done/err", 64'({rd_valid, wr_ready, done, err}), 64'(4'b0000));
    check("rst adr", 64'(wb_adr), 64'(0));
    check("rst dat_o", 64'(wb_dat_o), 64'(0));
    check("rst cti/bte", 64'({wb_cti, wb_bte}), 64'(5'b0));
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("rst cmd_ready", 64'(cmd_ready), 64'(1));
    check("sel all ones", 64'(wb_sel), 64'(4'hF));

    // ---------------- table-driven vectors ----------------
    for (int i = 0; i < NV; i++) begin
      @(posedge clk);
      #1;
      cmd_valid = vt[i].cv;
      cmd_we    = vt[i].cwe;
      cmd_adr   = vt[i].cadr;
      cmd_len   = vt[i].clen;
      cmd_bte   = vt[i].cbte;
      wr_valid  = vt[i].wv;
      wb_ack    = vt[i].ack;
      wb_err    = vt[i].er;
      wb_rty    = vt[i].rty;
      wr_dat    = 32'hA000_0000 + 32'(i);
      wb_dat_i  = 32'hD000_0000 + 32'(i);
      #1;
      check($sformatf("vec%0d rdy,cyc,stb,we,adr,cti,bte,rdv,wrr,done,err", i),
            64'({cmd_ready, wb_cyc, wb_stb, wb_we, wb_adr, wb_cti, wb_bte,
                 rd_valid, wr_ready, done, err}),
            64'({vt[i].e_rdy, vt[i].e_cyc, vt[i].e_stb, vt[i].e_we, vt[i].e_adr,
                 vt[i].e_cti, vt[i].e_bte, vt[i].e_rdv, vt[i].e_wrr, vt[i].e_done,
                 vt[i].e_err}));
      if (vt[i].e_rdv)
        check($sformatf("vec%0d rd_dat", i), 64'(rd_dat), 64'(32'hD000_0000 + 32'(i)));
      if (vt[i].e_cyc && vt[i].e_we)
        check($sformatf("vec%0d wb_dat_o", i), 64'(wb_dat_o), 64'(32'hA000_0000 + 32'(i)));
    end

    // ---------------- write with 2-cycle data stall ----------------
    @(posedge clk); #1;
    cmd_valid = 1'b1; cmd_we = 1'b1; cmd_adr = 32'h40; cmd_len = 4'd1; cmd_bte = 2'b00;
    wr_valid = 1'b1; wb_ack = 1'b0; wb_err = 1'b0; wb_rty = 1'b0;
    @(posedge clk); #1;
    cmd_valid = 1'b0; wb_ack = 1'b1;
    #1;
    check("stall beat0 wrr/adr/cti", 64'({wr_ready, wb_adr, wb_cti}), 64'({1'b1, 32'h40, 3'b010}));
    for (int k = 0; k < 2; k++) begin
      @(posedge clk); #1;
      wr_valid = 1'b0;      // slave keeps ack high; without stb it must not count
      #1;
      check($sformatf("stall wait%0d stb,cyc,adr,wrr", k),
            64'({wb_stb, wb_cyc, wb_adr, wr_ready}), 64'({1'b0, 1'b1, 32'h44, 1'b0}));
    end
    @(posedge clk); #1;
    wr_valid = 1'b1;
    #1;
    check("stall beat1 stb,wrr,cti,adr", 64'({wb_stb, wr_ready, wb_cti, wb_adr}),
          64'({1'b1, 1'b1, 3'b111, 32'h44}));
    @(posedge clk); #1;
    wr_valid = 1'b0; wb_ack = 1'b0;
    #1;
    check("stall done,cyc", 64'({done, wb_cyc}), 64'({1'b1, 1'b0}));

`ifdef WB_MASTER_TIMEOUT_EN
    // ---------------- watchdog abort ----------------
    @(posedge clk); #1;
    cmd_valid = 1'b1; cmd_we = 1'b0; cmd_adr = 32'h0; cmd_len = 4'd3; cmd_bte = 2'b00;
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    stb_cnt = 0;
    for (int k = 0; k < 40; k++) begin
      #1;
      if (!wb_cyc) break;
      if (wb_stb) stb_cnt++;
      @(posedge clk); #1;
    end
    check("timeout strobe cycles", 64'(stb_cnt), 64'(8));
    check("timeout done,err", 64'({done, err}), 64'({1'b1, 1'b1}));
`else
    // ---------------- no watchdog: slave silence waits forever ----------------
    @(posedge clk); #1;
    cmd_valid = 1'b1; cmd_we = 1'b0; cmd_adr = 32'h0; cmd_len = 4'd3; cmd_bte = 2'b00;
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    done_seen = 0;
    for (int k = 0; k < 20; k++) begin
      @(posedge clk); #2;
      if (done) done_seen++;
    end
    check("hang cyc,stb,err", 64'({wb_cyc, wb_stb, err}), 64'({1'b1, 1'b1, 1'b0}));
    check("hang no done", 64'(done_seen), 64'(0));
    @(posedge clk); #1;
    wb_rty = 1'b1;
    @(posedge clk); #1;
    wb_rty = 1'b0;
    #1;
    check("hang rty done,err,cyc", 64'({done, err, wb_cyc}), 64'({1'b1, 1'b0, 1'b0}));
`endif

    // ---------------- asynchronous reset mid-burst ----------------
    @(posedge clk); #1;
    cmd_valid = 1'b1; cmd_we = 1'b0; cmd_adr = 32'h80; cmd_len = 4'd15; cmd_bte = 2'b00;
    @(posedge clk); #1;
    cmd_valid = 1'b0; wb_ack = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    wb_ack = 1'b0;
    #1;
    check("mid cyc,adr", 64'({wb_cyc, wb_adr}), 64'({1'b1, 32'h88}));
    #2;
    rst_n = 1'b0;
    #1;
    check("async rst cyc,stb", 64'({wb_cyc, wb_stb}), 64'(2'b00));
    done_seen = 0;
    for (int k = 0; k < 2; k++) begin
      @(posedge clk); #1;
      if (done) done_seen++;
    end
    check("async rst no done", 64'(done_seen), 64'(0));
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("post rst rdy,adr,err,cyc", 64'({cmd_ready, wb_adr, err, wb_cyc}),
          64'({1'b1, 32'h0, 1'b0, 1'b0}));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/wb_b3_burst_master.md
WB_B3_BURST_MASTER -- requirements
Module: wb_b3_burst_master

Interface
REQ-001 SHALL have parameter dw, default 32, data width in bits (multiple of 8).
REQ-002 SHALL have parameter aw, default 32, address width in bits.
REQ-003 SHALL have parameter TIMEOUT_CYCLES, default 255, watchdog limit (used only with WB_MASTER_TIMEOUT_EN).
REQ-004 SHALL have exactly one clock and reset: asynchronous, active-low.
  - wb_clk_i, in, 1: clock, single clock domain.
  - wb_rst_n_i, in, 1: reset, asynchronous assert, active-low.
REQ-005 SHALL provide the command and data ports below.
  - cmd_valid_i, in, 1: command request.
  - cmd_ready_o, out, 1: command accepted when cmd_valid_i & cmd_ready_o.
  - cmd_we_i, in, 1: 1 = write burst, 0 = read burst.
  - cmd_adr_i, in, aw: byte start address, word aligned.
  - cmd_len_i, in, 4: beats minus 1 (0..15).
  - cmd_bte_i, in, 2: burst type (00 linear, 01 wrap4, 10 wrap8, 11 wrap16).
  - wr_dat_i, in, dw: write data.
  - wr_valid_i, in, 1: write data available.
  - wr_ready_o, out, 1: write beat consumed.
  - rd_dat_o, out, dw: read data.
  - rd_valid_o, out, 1: read beat valid, single-cycle pulse.
  - done_o, out, 1: one-cycle pulse at end of command.
  - err_o, out, 1: sticky status of the last command (error or timeout); cleared on next command accept.
REQ-006 SHALL provide the Wishbone B3 master ports below.
  - wb_adr_o, out, aw: bus address.
  - wb_dat_o, out, dw: bus write data.
  - wb_sel_o, out, dw/8: byte selects, always all-ones.
  - wb_we_o, out, 1: write enable.
  - wb_cyc_o, out, 1: cycle.
  - wb_stb_o, out, 1: strobe.
  - wb_cti_o, out, 3: cycle type identifier.
  - wb_bte_o, out, 2: burst type extension.
  - wb_dat_i, in, dw: bus read data.
  - wb_ack_i, in, 1: acknowledge.
  - wb_err_i, in, 1: error.
  - wb_rty_i, in, 1: retry.

Function
REQ-007 SHALL implement the FSM states IDLE, BUS, and DONE; cmd_ready_o SHALL be 1 only in IDLE.
REQ-008 On command accept, the block SHALL latch we, adr, len, and bte and go to BUS next cycle with wb_cyc_o=1, wb_adr_o=start address, and the beat counter = len.
REQ-009 In BUS, wb_stb_o SHALL be 1 for reads; for writes, wb_stb_o SHALL equal wr_valid_i (wait state while 0), and wb_dat_o SHALL equal wr_dat_i.
REQ-010 wb_cti_o SHALL be 000 when len=0; otherwise 010 while the beat counter > 0 and 111 on the final beat.
REQ-011 A beat completes on wb_stb_o & wb_ack_i: writes SHALL pulse wr_ready_o, reads SHALL pulse rd_valid_o with rd_dat_o=wb_dat_i in the same cycle, and the beat counter SHALL decrement.
REQ-012 The address SHALL advance by dw/8 bytes per completed beat; linear SHALL be a full-width increment, and wrap4/8/16 SHALL increment only word-address bits [1:0]/[2:0]/[3:0] with the upper bits held.
REQ-013 wb_adr_o SHALL be registered and updated in the ack cycle, so the next beat presents the new address in the following cycle (no bubble; back-to-back acks sustained at 1 beat/cycle).
REQ-014 Ack on the final beat, or wb_err_i, or wb_rty_i SHALL drop wb_cyc_o and wb_stb_o the next cycle and go to DONE.
REQ-015 err_o SHALL be set on wb_err_i or timeout; wb_rty_i terminates the command without setting err_o and without retrying.
REQ-016 DONE SHALL last one cycle, pulse done_o, and return to IDLE; a command accepted in the cycle after DONE SHALL be legal.
REQ-017 The block SHALL ignore wb_ack_i/wb_err_i/wb_rty_i while wb_cyc_o=0; if err and ack are asserted together, err SHALL win and no data beat is counted.

Reset
REQ-018 While wb_rst_n_i=0, the FSM SHALL be IDLE; wb_cyc_o, wb_stb_o, wb_we_o, rd_valid_o, wr_ready_o, done_o, and err_o SHALL be 0; wb_adr_o and wb_dat_o SHALL be 0; wb_cti_o=000 and wb_bte_o=00; cmd_ready_o=1 after reset release.
REQ-019 Reset asserted mid-burst SHALL drop wb_cyc_o immediately (asynchronously), with no done_o pulse.

Configuration
REQ-020 With WB_MASTER_TIMEOUT_EN defined, a counter SHALL clear on every ack and count while in BUS with wb_stb_o=1; reaching TIMEOUT_CYCLES SHALL abort as in REQ-014 and set err_o. Without WB_MASTER_TIMEOUT_EN, there SHALL be no counter and the block SHALL wait indefinitely.

Structure
REQ-021 The package wb_b3_pkg SHALL hold the CTI codes (CLASSIC=000, CONST=001, INCR=010, EOB=111), the BTE codes, and the FSM state type.
REQ-022 Address stepping SHALL be in the sub-module wb_b3_adr_gen (combinational next address from current address, bte, and dw).

Verification
REQ-023 Read, adr=0x0, len=3, bte=00, slave acks every cycle -> cti 010,010,010,111; adr 0x0,0x4,0x8,0xC; 4 rd_valid_o pulses; one done_o pulse; err_o=0.
REQ-024 Write, adr=0x8, len=3, bte=01 -> adr 0x8,0xC,0x0,0x4; 4 wr_ready_o pulses.
REQ-025 Write, len=1, wr_valid_i low for 2 cycles mid-burst -> wb_stb_o low for 2 cycles, wb_cyc_o held, wb_adr_o held, then completes.
REQ-026 Single read, len=0 -> cti=000; wb_err_i on first response -> cyc drops next cycle, err_o=1, done_o pulses, rd_valid_o=0.
REQ-027 With WB_MASTER_TIMEOUT_EN and TIMEOUT_CYCLES=8, slave never acks -> abort after 8 strobe cycles with err_o=1; reset asserted mid-burst -> wb_cyc_o=0 immediately.
